// File: rtl/dmem_wait_responder.sv
// Wait-state data memory responder for the MEM stage: accepts one access, holds the
// pipeline for WAIT_CYCLES+1 cycles, then returns a one-cycle mem_ready pulse with read data.
module dmem_wait_responder #(
  parameter int DEPTH       = 256,
  parameter int AW          = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          op_wr_q, op_wr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH];

  logic          req;
  logic          enter_resp;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_wdata;
  logic          acc_wr;
  logic          commit_wr;

  // Upper address bits are don't-care: accesses wrap modulo DEPTH words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:AW+2];

  assign req = mem_read | mem_write;

  // With zero wait states the RESP edge is also the acceptance edge, so the access
  // must use the live request fields instead of the (not yet loaded) latched ones.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_idx   = addr[AW+1:2];
      acc_wdata = wdata;
      acc_wr    = mem_write;
    end else begin
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_wr    = op_wr_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    op_wr_d    = op_wr_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d   = addr[AW+1:2];
          wdata_d = wdata;
          op_wr_d = mem_write;
          cnt_d   = 4'(WAIT_CYCLES);
          err_d   = err_q | (addr[1:0] != 2'b00) | (mem_read & mem_write);
          if (WAIT_CYCLES == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
          cnt_d      = 4'd0;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign commit_wr = enter_resp & acc_wr;

  // Writes return zero; reads capture the word on the edge that enters RESP and hold it.
  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp) begin
      rdata_d = acc_wr ? 32'd0 : mem[acc_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      op_wr_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      op_wr_q <= op_wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is never reset; a reset held across an edge must not commit a write.
  always_ff @(posedge clk) begin
    if (commit_wr && reset) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign mem_ready = (state_q == ST_RESP);
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign stall     = req & ~mem_ready;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder: one instance with two wait states, one with none.
module tb_dmem_wait_responder;

  logic        clk;
  logic        rst0, rst2;
  logic        rd0, wr0, rd2, wr2;
  logic [31:0] a0, wd0, a2, wd2;
  logic [31:0] rdata0, rdata2;
  logic        rdy0, rdy2, stall0, stall2, err0, err2;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_wait_responder #(.DEPTH(256), .AW(8), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(rst2), .mem_read(rd2), .mem_write(wr2), .addr(a2), .wdata(wd2),
    .rdata(rdata2), .mem_ready(rdy2), .stall(stall2), .err(err2)
  );

  dmem_wait_responder #(.DEPTH(256), .AW(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst0), .mem_read(rd0), .mem_write(wr0), .addr(a0), .wdata(wd0),
    .rdata(rdata0), .mem_ready(rdy0), .stall(stall0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit d0, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (d0) begin
      rd0 = r; wr0 = w; a0 = a; wd0 = d;
    end else begin
      rd2 = r; wr2 = w; a2 = a; wd2 = d;
    end
  endtask

  // One full access: present the request, count stall cycles until mem_ready, check the response.
  task automatic do_access(input bit d0, input bit r, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err,
                           input string tag);
    int  lat;
    bit  seen;
    logic rdy, stl, er;
    logic [31:0] rdv;
    lat  = 0;
    seen = 1'b0;
    @(posedge clk); #1;
    drive(d0, r, w, a, d);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      rdy = d0 ? rdy0 : rdy2;
      stl = d0 ? stall0 : stall2;
      if (rdy) begin
        seen = 1'b1;
      end else begin
        check_val({tag, "_stall"}, {31'd0, stl}, 32'd1);
        lat++;
      end
    end
    rdv = d0 ? rdata0 : rdata2;
    stl = d0 ? stall0 : stall2;
    er  = d0 ? err0 : err2;
    check_val({tag, "_ready_seen"}, {31'd0, seen}, 32'd1);
    check_val({tag, "_stall_cycles"}, lat, d0 ? 32'd1 : 32'd3);
    check_val({tag, "_rdata"}, rdv, exp_rd);
    check_val({tag, "_stall_at_ready"}, {31'd0, stl}, 32'd0);
    check_val({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    $display("[TB] %s: addr=0x%08h rd=%0b wr=%0b wdata=0x%08h rdata=0x%08h stall_cycles=%0d err=%0b",
             tag, a, r, w, d, rdv, lat, er);
    drive(d0, 1'b0, 1'b0, a, d);
  endtask

  initial begin
    rst0 = 1'b0; rst2 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready2", {31'd0, rdy2}, 32'd0);
    check_val("rst_rdata2", rdata2, 32'd0);
    check_val("rst_err2", {31'd0, err2}, 32'd0);
    check_val("rst_ready0", {31'd0, rdy0}, 32'd0);
    @(posedge clk); #1;
    rst0 = 1'b1; rst2 = 1'b1;

    // Idle with no request: nothing moves.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("idle_ready", {31'd0, rdy2}, 32'd0);
      check_val("idle_stall", {31'd0, stall2}, 32'd0);
    end
    $display("[TB] idle: ready=%0b stall=%0b", rdy2, stall2);

    // Basic write then read-back, two wait states.
    do_access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, "t1_wr");
    @(posedge clk); #1;
    @(negedge clk);
    check_val("t1_ready_after", {31'd0, rdy2}, 32'd0);
    check_val("t1_stall_after", {31'd0, stall2}, 32'd0);
    do_access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "t2_rd");

    // Zero wait states: write, then a read held high across two responses.
    do_access(1'b1, 1'b0, 1'b1, 32'h4, 32'h1, 32'd0, 1'b0, "t3_wr");
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val($sformatf("t3_hold_ready%0d", i), {31'd0, rdy0}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check_val($sformatf("t3_hold_stall%0d", i), {31'd0, stall0}, (i % 2 == 1) ? 32'd0 : 32'd1);
      if (i % 2 == 1) check_val($sformatf("t3_hold_rdata%0d", i), rdata0, 32'h1);
      $display("[TB] t3_hold cycle %0d: ready=%0b stall=%0b rdata=0x%08h", i, rdy0, stall0, rdata0);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Address wrap modulo DEPTH words.
    do_access(1'b0, 1'b0, 1'b1, 32'h400, 32'h55, 32'd0, 1'b0, "t4_wr_wrap");
    do_access(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h55, 1'b0, "t4_rd_wrap");

    // Read+write together acts as a write and sets err; misaligned read also flags.
    do_access(1'b0, 1'b1, 1'b1, 32'h8, 32'h77, 32'd0, 1'b1, "t5_rdwr");
    do_access(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 32'h77, 1'b1, "t5_rd8");
    do_access(1'b0, 1'b1, 1'b0, 32'h9, 32'h0, 32'h77, 1'b1, "t5_rd9");

    // Reset during WAIT aborts the pending write.
    do_access(1'b0, 1'b0, 1'b1, 32'h20, 32'hAA, 32'd0, 1'b1, "t6_wrAA");
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hBB);
    @(negedge clk);
    check_val("t6_stall_pre", {31'd0, stall2}, 32'd1);
    @(posedge clk); #1;
    rst2 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check_val("t6_rst_ready", {31'd0, rdy2}, 32'd0);
    check_val("t6_rst_rdata", rdata2, 32'd0);
    check_val("t6_rst_err", {31'd0, err2}, 32'd0);
    check_val("t6_rst_stall", {31'd0, stall2}, 32'd0);
    @(posedge clk); #1;
    rst2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("t6_no_ready", {31'd0, rdy2}, 32'd0);
    end
    $display("[TB] t6_reset: ready=%0b rdata=0x%08h err=%0b", rdy2, rdata2, err2);
    do_access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'hAA, 1'b0, "t6_rd20");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
